// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start bit, LSB-first data, parity bit, stop bit.
// Reports data, parity/stop errors and a saturating error count per frame.
module parity_frame_checker #(
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  serial_in,
    input  logic                  bit_valid,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  frame_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [CW-1:0]         cnt;
    logic                  par;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  perr_now;
    logic                  ferr_now;

    assign perr_now = par ^ ODD;
    assign ferr_now = ~serial_in;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the FSM only advances on sampled bits
    always_comb begin
        state_next = state;
        if (bit_valid) begin
            unique case (state)
                IDLE:   if (!serial_in) state_next = DATA;
                DATA:   if (cnt == LAST) state_next = PARITY;
                PARITY: state_next = STOP;
                STOP:   state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath: bit capture, running parity and frame result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            par         <= 1'b0;
            shreg       <= '0;
            data_out    <= '0;
            frame_valid <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            frame_valid <= 1'b0;
            if (bit_valid) begin
                unique case (state)
                    IDLE: begin
                        cnt <= '0;
                        par <= 1'b0;
                    end
                    DATA: begin
                        shreg[cnt] <= serial_in;
                        par        <= par ^ serial_in;
                        cnt        <= cnt + CW'(1);
                    end
                    PARITY: begin
                        par <= par ^ serial_in;
                    end
                    STOP: begin
                        data_out    <= shreg;
                        parity_err  <= perr_now;
                        frame_err   <= ferr_now;
                        frame_valid <= 1'b1;
                        if ((perr_now | ferr_now) && err_count != 8'hFF)
                            err_count <= err_count + 8'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Bench for parity_frame_checker: even and odd instances share one line,
// a queue-based frame model is compared every cycle, plus literal checks.
module tb_parity_frame_checker;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         serial_in = 1'b1;
    logic         bit_valid = 1'b0;

    logic [W-1:0] data_e, data_o;
    logic         fv_e, fv_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;
    logic [7:0]   cnt_e, cnt_o;

    int tests = 0;
    int fails = 0;

    parity_frame_checker #(.DATA_WIDTH(W), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_valid(bit_valid),
        .data_out(data_e), .frame_valid(fv_e), .parity_err(perr_e),
        .frame_err(ferr_e), .busy(busy_e), .err_count(cnt_e)
    );

    parity_frame_checker #(.DATA_WIDTH(W), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .bit_valid(bit_valid),
        .data_out(data_o), .frame_valid(fv_o), .parity_err(perr_o),
        .frame_err(ferr_o), .busy(busy_o), .err_count(cnt_o)
    );

    always #5 clk = ~clk;

    // Model: collect sampled frame bits, evaluate the frame once complete
    bit           q[$];
    logic [W-1:0] m_data = '0;
    logic         m_fv = 0, m_perr_e = 0, m_perr_o = 0, m_ferr = 0;
    int           m_cnt_e = 0, m_cnt_o = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_data = '0; m_fv = 0; m_perr_e = 0; m_perr_o = 0; m_ferr = 0;
            m_cnt_e = 0; m_cnt_o = 0;
        end else begin
            m_fv = 0;
            if (bit_valid) begin
                if (q.size() != 0 || serial_in == 1'b0) q.push_back(serial_in);
                if (q.size() == W + 3) begin
                    int ones;
                    for (int i = 0; i < W; i++) m_data[i] = q[1 + i];
                    ones = $countones(m_data) + int'(q[W + 1]);
                    m_perr_e = (ones % 2) != 0;
                    m_perr_o = (ones % 2) == 0;
                    m_ferr = !q[W + 2];
                    m_fv = 1;
                    if ((m_perr_e || m_ferr) && m_cnt_e < 255) m_cnt_e++;
                    if ((m_perr_o || m_ferr) && m_cnt_o < 255) m_cnt_o++;
                    q.delete();
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("fv_e", int'(fv_e), int'(m_fv));
        check("fv_o", int'(fv_o), int'(m_fv));
        check("busy_e", int'(busy_e), int'(q.size() != 0));
        check("busy_o", int'(busy_o), int'(q.size() != 0));
        check("data_e", int'(data_e), int'(m_data));
        check("data_o", int'(data_o), int'(m_data));
        check("perr_e", int'(perr_e), int'(m_perr_e));
        check("perr_o", int'(perr_o), int'(m_perr_o));
        check("ferr_e", int'(ferr_e), int'(m_ferr));
        check("ferr_o", int'(ferr_o), int'(m_ferr));
        check("cnt_e", int'(cnt_e), m_cnt_e);
        check("cnt_o", int'(cnt_o), m_cnt_o);
    end

    int fv_seen;
    always @(posedge clk) if (fv_e) fv_seen++;

    task automatic drive_bit(input logic b, input bit gaps);
        if (gaps) begin
            int n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) begin
                @(posedge clk); #1;
                bit_valid = 1'b0;
                serial_in = $urandom_range(0, 1);
            end
        end
        @(posedge clk); #1;
        serial_in = b;
        bit_valid = 1'b1;
    endtask

    // Sends a frame; returns just after the edge that samples the stop bit
    task automatic send_frame(input logic [W-1:0] d, input logic p,
                              input logic stop, input bit gaps);
        drive_bit(1'b0, gaps);
        for (int i = 0; i < W; i++) drive_bit(d[i], gaps);
        drive_bit(p, gaps);
        drive_bit(stop, gaps);
        @(posedge clk); #1;
        bit_valid = 1'b0;
        serial_in = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bit_valid = 1'b0;
            serial_in = 1'b1;
        end
    endtask

    initial begin
        #1;
        check("rst_busy", int'(busy_e), 0);
        check("rst_cnt", int'(cnt_e), 0);
        #20 rst_n = 1'b1;
        idle(2);

        send_frame(8'hA5, 1'b0, 1'b1, 0);
        check("a5_fv", int'(fv_e), 1);
        check("a5_data", int'(data_e), 'hA5);
        check("a5_perr", int'(perr_e), 0);
        check("a5_cnt", int'(cnt_e), 0);
        idle(2);
        check("a5_fv_gone", int'(fv_e), 0);
        check("a5_hold", int'(data_e), 'hA5);

        send_frame(8'h01, 1'b0, 1'b1, 0);
        check("01_perr", int'(perr_e), 1);
        check("01_cnt", int'(cnt_e), 1);
        check("01_odd_perr", int'(perr_o), 0);
        idle(1);

        send_frame(8'h3C, 1'b0, 1'b0, 0);
        check("3c_ferr", int'(ferr_e), 1);
        check("3c_perr", int'(perr_e), 0);
        check("3c_cnt", int'(cnt_e), 2);
        send_frame(8'h55, 1'b0, 1'b1, 0);
        check("55_data", int'(data_e), 'h55);
        check("55_ferr", int'(ferr_e), 0);
        check("55_perr", int'(perr_e), 0);
        idle(2);

        fv_seen = 0;
        send_frame(8'h5A, 1'b0, 1'b1, 1);
        idle(3);
        check("5a_data", int'(data_e), 'h5A);
        check("5a_once", fv_seen, 1);

        drive_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("mid_busy", int'(busy_e), 0);
        check("mid_data", int'(data_e), 0);
        check("mid_cnt", int'(cnt_e), 0);
        bit_valid = 1'b0;
        serial_in = 1'b1;
        #10 rst_n = 1'b1;
        idle(2);
        send_frame(8'hC3, 1'b0, 1'b1, 0);
        check("c3_data", int'(data_e), 'hC3);
        check("c3_err", int'(perr_e | ferr_e), 0);

        for (int f = 0; f < 260; f++) begin
            send_frame(8'h01, 1'b0, 1'b1, 0);
            if (f == 254) check("sat_255", int'(cnt_e), 255);
        end
        idle(2);
        check("sat_hold", int'(cnt_e), 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: run did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/parity_frame_checker.md
PARITY_FRAME_CHECKER -- requirements
Module: parity_frame_checker

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8: number of data bits per frame, legal range 1..16.
REQ-002 The module SHALL have parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 The module SHALL have input clk, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have input rst_n, 1 bit: reset is asynchronous and active-low.
REQ-005 The module SHALL have input serial_in, 1 bit: the serial line, sampled only when bit_valid=1.
REQ-006 The module SHALL have input bit_valid, 1 bit: sample strobe; one frame bit is consumed per clk edge with bit_valid=1.
REQ-007 The module SHALL have output data_out, DATA_WIDTH bits: data of the last completed frame.
REQ-008 The module SHALL have output frame_valid, 1 bit: one-cycle pulse marking completion of a frame.
REQ-009 The module SHALL have output parity_err, 1 bit: parity mismatch of the last completed frame.
REQ-010 The module SHALL have output frame_err, 1 bit: stop bit of the last completed frame was 0.
REQ-011 The module SHALL have output busy, 1 bit: high while the FSM is outside IDLE.
REQ-012 The module SHALL have output err_count, 8 bits: count of frames with parity_err or frame_err set.

Function
REQ-013 Frame format SHALL be: start bit (0), DATA_WIDTH data bits LSB first, one parity bit, stop bit (1).
REQ-014 The FSM SHALL have states IDLE, DATA, PARITY, STOP; it SHALL change state only on edges with bit_valid=1.
REQ-015 In IDLE, a sampled 0 SHALL move to DATA and clear the bit counter and running parity; a sampled 1 SHALL stay in IDLE.
REQ-016 In DATA, each sample SHALL shift into the data register at bit index = counter and XOR into the running parity; after the DATA_WIDTH-th sample, the FSM SHALL move to PARITY.
REQ-017 In PARITY, the sample SHALL be XORed into the running parity and the FSM SHALL move to STOP.
REQ-018 parity_err SHALL be computed as (running parity XOR PARITY_ODD) != 0: even mode flags odd ones-count over data+parity; odd mode flags even ones-count.
REQ-019 In STOP, the sample SHALL end the frame: at that edge, data_out, parity_err and frame_err (= NOT sample) SHALL be registered, frame_valid SHALL go high for exactly the following cycle, and the FSM SHALL return to IDLE.
REQ-020 Latency: frame_valid SHALL be high in the cycle immediately after the edge that samples the stop bit, independent of bit_valid in that cycle.
REQ-021 data_out, parity_err and frame_err SHALL hold their values until the next frame completes; partial frames SHALL NOT modify them.
REQ-022 A stop-bit 0 SHALL still return the FSM to IDLE; the next frame SHALL begin at the next sampled 0.
REQ-023 err_count SHALL increment by 1 on each completed frame with parity_err or frame_err and SHALL saturate at 255.
REQ-024 Gaps (bit_valid=0) of any length mid-frame SHALL freeze FSM, counter and parity without affecting the result.
REQ-025 busy SHALL be 0 in IDLE and 1 in DATA, PARITY and STOP.

Reset
REQ-026 rst_n=0 SHALL immediately, without waiting for clk, force IDLE, counter 0, running parity 0, data_out 0, frame_valid 0, parity_err 0, frame_err 0, busy 0, err_count 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release, the first sampled 0 SHALL start a new frame.
REQ-028 The first edge after rst_n deassertion SHALL be a normal operating edge.

Verification
REQ-029 Even mode, frame 0,(0xA5 LSB first),0,1 with bit_valid=1 every cycle -> frame_valid pulse one cycle after stop edge, data_out=0xA5, parity_err=0, frame_err=0, err_count=0.
REQ-030 Even mode, data 0x01 with parity bit 0 -> data_out=0x01, parity_err=1, frame_err=0, err_count=1; PARITY_ODD=1 with same frame -> parity_err=0.
REQ-031 Data 0x3C, correct parity, stop bit 0 -> frame_err=1, parity_err=0, err_count increments; next valid frame 0x55 -> data_out=0x55, both errors 0.
REQ-032 Frame 0x5A with bit_valid toggled 1,0,0,1,... (random gaps) -> result identical to gap-free frame, frame_valid exactly once.
REQ-033 rst_n pulsed low after 4 data bits of a frame -> all outputs 0 immediately, busy=0; subsequent full frame 0xC3 -> data_out=0xC3, no errors.
REQ-034 260 consecutive parity-error frames -> err_count reaches 255 and stays 255.
